ov5640_init_sequencer: RTL and testbench
========================================

# ov5640_init_sequencer

Register-table walker that drives the OV5640 SCCB configuration block. After reset it waits out the camera power-up interval. It then fetches {address, data} entries from an external synchronous table ROM and issues one SCCB write per entry over the start/ready handshake. It supports in-table delay entries, end-of-table detection, transaction timeout and restart. It sits directly upstream of the camera SCCB config stage, feeding its `start_ov5640` / `address_ov5640` / `data_ov5640` / `select_initial_cam` inputs and consuming `ready_ov5640`.

## Interface
- `POWER_WAIT_CYCLES`, 2_000_000: clk_sys cycles from reset release to first fetch (20 ms at 100 MHz).
- `DELAY_UNIT_CYCLES`, 100_000: clk_sys cycles per delay unit in a delay entry (1 ms).
- `TIMEOUT_CYCLES`, 1_000_000: maximum cycles allowed in each SCCB wait state.
- `ROM_AW`, 8: table address width; the table holds at most 2^ROM_AW entries.
- `CAM_SEL`, 2'b00: value driven on `select_initial_cam` while busy (00 = both cameras).

Ports:
- `clk_sys`  in  1  system clock; the only clock.
- `reset`  in  1  asynchronous, active-high reset.
- `restart`  in  1  single-cycle pulse that re-runs the sequence from POWER_WAIT.
- `rom_addr`  out  ROM_AW  table index (registered).
- `rom_data`  in  24  table entry {addr[23:8], data[7:0]}, valid one cycle after `rom_addr`.
- `start_ov5640`  out  1  one-cycle write request to the SCCB stage.
- `address_ov5640`  out  16  SCCB register address; held from start until the transaction completes.
- `data_ov5640`  out  8  SCCB register data; held like `address_ov5640`.
- `ready_ov5640`  in  1  SCCB stage idle (high) or busy (low).
- `select_initial_cam`  out  2  camera select: CAM_SEL while busy, 2'b11 otherwise.
- `config_busy`  out  1  high from reset release until DONE or ERROR.
- `config_done`  out  1  high in DONE.
- `config_error`  out  1  high in ERROR.
- `err_index`  out  ROM_AW  table index that timed out; valid while `config_error` is high.

## Operation
- **Reset values:** state POWER_WAIT. All counters, `rom_addr`, `start_ov5640`, `address_ov5640`, `data_ov5640`, `config_done`, `config_error` and `err_index` are 0. `config_busy` = 1 and `select_initial_cam` = CAM_SEL.
- **Table entry decode** (addr field):
  - 16'hFFFF: end of table.
  - 16'hFFFE: delay of data × DELAY_UNIT_CYCLES cycles.
  - Any other value: SCCB write.
- **States:**
  - POWER_WAIT: count to POWER_WAIT_CYCLES-1, then go to FETCH.
  - FETCH: `rom_addr` is stable for one cycle, then go to DECODE.
  - DECODE: sample `rom_data`.
    - End marker: go to DONE.
    - Delay entry with data = 0: go to NEXT.
    - Delay entry with data > 0: load the delay counter and go to DELAY.
    - Write entry: latch address and data, go to START.
  - START: wait for `ready_ov5640` = 1, then pulse `start_ov5640` for exactly one cycle and go to WAIT_ACK.
  - WAIT_ACK: wait for `ready_ov5640` = 0, then go to WAIT_DONE.
  - WAIT_DONE: wait for `ready_ov5640` = 1, then go to NEXT.
  - DELAY: count down data × DELAY_UNIT_CYCLES cycles, then go to NEXT.
  - NEXT: if `rom_addr` = 2^ROM_AW-1, go to DONE (implicit end, no wrap). Otherwise increment `rom_addr` and go to FETCH.
  - DONE / ERROR: terminal states. Leave only on `restart`.
- **Timeout:** one cycle counter, cleared on entry to START, WAIT_ACK and WAIT_DONE. Reaching TIMEOUT_CYCLES in any of those states goes to ERROR, with `err_index` = `rom_addr`.
- **restart:** honoured only in DONE or ERROR. It clears `rom_addr`, `config_done`, `config_error` and `err_index`, and enters POWER_WAIT. It is ignored in all other states, so an SCCB frame is never truncated.
- **Delay arithmetic:** the delay counter is 8 + clog2(DELAY_UNIT_CYCLES+1) bits wide, so 255 units never overflow.

## Timing
- `rom_addr` → `rom_data` latency is 1 cycle. DECODE samples `rom_data` in the cycle after FETCH.
- `start_ov5640` goes high only in a cycle where `ready_ov5640` = 1, and is never high for two consecutive cycles.
- `address_ov5640` and `data_ov5640` are valid from the start cycle and stable until WAIT_DONE exits.
- Back-to-back writes: a new start no earlier than 3 cycles after `ready_ov5640` returns high (NEXT, FETCH, DECODE).
- Mid-operation reset: all outputs go to their reset values asynchronously and `start_ov5640` drops immediately.
- `config_busy` and `select_initial_cam` change on the same edge as the entry into DONE/ERROR.

## Test plan
Unless stated, the bench uses POWER_WAIT_CYCLES=10, DELAY_UNIT_CYCLES=4, TIMEOUT_CYCLES=50 and ROM_AW=3.
- **Basic sequence:** table {3008/82, 3103/03, FFFF/00}, with an SCCB model that holds ready low for 20 cycles. Required: the first start occurs after ≥10 cycles; exactly 2 starts, carrying 16'h3008/8'h82 then 16'h3103/8'h03; `config_done`=1; `select_initial_cam` goes 00→11.
- **Delay entries:** table {FFFE/05, 3008/02, FFFF}. Required: a gap of ≥20 cycles between DECODE of entry 0 and the start. FFFE/00 yields no added delay.
- **Timeout:** `ready_ov5640` never drops after the start of entry 1. Required: ERROR reached 50 cycles after the start; `err_index`=1; `config_busy`=0; no further starts.
- **Full table without end marker:** 8 write entries. Required: 8 starts, then DONE, with `rom_addr` held at 7 (no wrap).
- **Restart and reset:** a `restart` pulse during WAIT_DONE is ignored. In DONE, `restart` re-runs the full table after the power wait. Asserting `reset` mid-START drops `start_ov5640` the same cycle and the sequence restarts from POWER_WAIT.

Source files
------------

// File: rtl/ov5640_init_sequencer.sv
// OV5640 init sequencer: waits out camera power-up, then walks a {addr,data} table ROM
// and issues one SCCB write per entry, with delay entries, end marker, timeout and restart.
module ov5640_init_sequencer #(
    parameter int         POWER_WAIT_CYCLES = 2_000_000,
    parameter int         DELAY_UNIT_CYCLES = 100_000,
    parameter int         TIMEOUT_CYCLES    = 1_000_000,
    parameter int         ROM_AW            = 8,
    parameter logic [1:0] CAM_SEL           = 2'b00
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              restart,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              start_ov5640,
    output logic [15:0]       address_ov5640,
    output logic [7:0]        data_ov5640,
    input  logic              ready_ov5640,
    output logic [1:0]        select_initial_cam,
    output logic              config_busy,
    output logic              config_done,
    output logic              config_error,
    output logic [ROM_AW-1:0] err_index
);

    localparam int PW_W  = $clog2(POWER_WAIT_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DLY_W = 8 + $clog2(DELAY_UNIT_CYCLES + 1);

    localparam logic [15:0]       ADDR_END   = 16'hFFFF;
    localparam logic [15:0]       ADDR_DELAY = 16'hFFFE;
    localparam logic [ROM_AW-1:0] LAST_IDX   = {ROM_AW{1'b1}};
    localparam logic [PW_W-1:0]   PW_LAST    = PW_W'(POWER_WAIT_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_POWER_WAIT,
        S_FETCH,
        S_DECODE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_DELAY,
        S_NEXT,
        S_DONE,
        S_ERROR
    } state_t;

    state_t            r_state;
    logic [PW_W-1:0]   r_pw_cnt;
    logic [TO_W-1:0]   r_to_cnt;
    logic [DLY_W-1:0]  r_dly_cnt;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_start;
    logic [15:0]       r_address;
    logic [7:0]        r_data;
    logic [1:0]        r_sel;
    logic              r_busy;
    logic              r_done;
    logic              r_error;
    logic [ROM_AW-1:0] r_err_index;

    logic [15:0]      w_entry_addr;
    logic [7:0]       w_entry_data;
    logic [DLY_W-1:0] w_delay_load;
    logic             w_to_expired;

    assign w_entry_addr = rom_data[23:8];
    assign w_entry_data = rom_data[7:0];
    // Widened before multiplying so a 255-unit delay cannot wrap.
    assign w_delay_load = DLY_W'(w_entry_data) * DLY_W'(DELAY_UNIT_CYCLES);
    assign w_to_expired = (r_to_cnt == TO_LAST);

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state     <= S_POWER_WAIT;
            r_pw_cnt    <= '0;
            r_to_cnt    <= '0;
            r_dly_cnt   <= '0;
            r_rom_addr  <= '0;
            r_start     <= 1'b0;
            r_address   <= '0;
            r_data      <= '0;
            r_sel       <= CAM_SEL;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_err_index <= '0;
        end else begin
            r_start <= 1'b0;
            case (r_state)
                S_POWER_WAIT: begin
                    if (r_pw_cnt == PW_LAST) begin
                        r_pw_cnt <= '0;
                        r_state  <= S_FETCH;
                    end else begin
                        r_pw_cnt <= r_pw_cnt + PW_W'(1);
                    end
                end

                S_FETCH: r_state <= S_DECODE;

                S_DECODE: begin
                    if (w_entry_addr == ADDR_END) begin
                        r_busy  <= 1'b0;
                        r_sel   <= 2'b11;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_entry_addr == ADDR_DELAY) begin
                        if (w_entry_data == 8'd0) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_dly_cnt <= w_delay_load;
                            r_state   <= S_DELAY;
                        end
                    end else begin
                        r_address <= w_entry_addr;
                        r_data    <= w_entry_data;
                        r_to_cnt  <= '0;
                        r_state   <= S_START;
                    end
                end

                S_START: begin
                    if (ready_ov5640) begin
                        r_start  <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_ACK;
                    end else if (w_to_expired) begin
                        r_busy      <= 1'b0;
                        r_sel       <= 2'b11;
                        r_error     <= 1'b1;
                        r_err_index <= r_rom_addr;
                        r_state     <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                S_WAIT_ACK: begin
                    if (!ready_ov5640) begin
                        r_to_cnt <= '0;
                        r_state  <= S_WAIT_DONE;
                    end else if (w_to_expired) begin
                        r_busy      <= 1'b0;
                        r_sel       <= 2'b11;
                        r_error     <= 1'b1;
                        r_err_index <= r_rom_addr;
                        r_state     <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                S_WAIT_DONE: begin
                    if (ready_ov5640) begin
                        r_state <= S_NEXT;
                    end else if (w_to_expired) begin
                        r_busy      <= 1'b0;
                        r_sel       <= 2'b11;
                        r_error     <= 1'b1;
                        r_err_index <= r_rom_addr;
                        r_state     <= S_ERROR;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end

                S_DELAY: begin
                    if (r_dly_cnt == DLY_W'(1)) begin
                        r_dly_cnt <= '0;
                        r_state   <= S_NEXT;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - DLY_W'(1);
                    end
                end

                // A full table ends here rather than wrapping back to entry 0.
                S_NEXT: begin
                    if (r_rom_addr == LAST_IDX) begin
                        r_busy  <= 1'b0;
                        r_sel   <= 2'b11;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_rom_addr <= r_rom_addr + ROM_AW'(1);
                        r_state    <= S_FETCH;
                    end
                end

                S_DONE, S_ERROR: begin
                    if (restart) begin
                        r_rom_addr  <= '0;
                        r_pw_cnt    <= '0;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                        r_err_index <= '0;
                        r_busy      <= 1'b1;
                        r_sel       <= CAM_SEL;
                        r_state     <= S_POWER_WAIT;
                    end
                end

                default: r_state <= S_POWER_WAIT;
            endcase
        end
    end

    assign rom_addr           = r_rom_addr;
    assign start_ov5640       = r_start;
    assign address_ov5640     = r_address;
    assign data_ov5640        = r_data;
    assign select_initial_cam = r_sel;
    assign config_busy        = r_busy;
    assign config_done        = r_done;
    assign config_error       = r_error;
    assign err_index          = r_err_index;

endmodule

// File: tb/tb_ov5640_init_sequencer.sv
// Self-checking bench for ov5640_init_sequencer: table ROM and SCCB stage models,
// expected write lists computed by walking the table with the decode rules.
module tb_ov5640_init_sequencer;

    localparam int         PW    = 10;
    localparam int         DU    = 4;
    localparam int         TO    = 50;
    localparam int         AW    = 3;
    localparam int         DEPTH = 1 << AW;
    localparam logic [1:0] CAM   = 2'b00;

    logic          clk_sys = 1'b0;
    logic          reset   = 1'b1;
    logic          restart = 1'b0;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data = '0;
    logic          start_ov5640;
    logic [15:0]   address_ov5640;
    logic [7:0]    data_ov5640;
    logic          ready_ov5640 = 1'b1;
    logic [1:0]    select_initial_cam;
    logic          config_busy;
    logic          config_done;
    logic          config_error;
    logic [AW-1:0] err_index;

    ov5640_init_sequencer #(
        .POWER_WAIT_CYCLES(PW),
        .DELAY_UNIT_CYCLES(DU),
        .TIMEOUT_CYCLES   (TO),
        .ROM_AW           (AW),
        .CAM_SEL          (CAM)
    ) dut (
        .clk_sys           (clk_sys),
        .reset             (reset),
        .restart           (restart),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .start_ov5640      (start_ov5640),
        .address_ov5640    (address_ov5640),
        .data_ov5640       (data_ov5640),
        .ready_ov5640      (ready_ov5640),
        .select_initial_cam(select_initial_cam),
        .config_busy       (config_busy),
        .config_done       (config_done),
        .config_error      (config_error),
        .err_index         (err_index)
    );

    always #5 clk_sys = ~clk_sys;

    logic [23:0] table_mem [DEPTH];
    always @(posedge clk_sys) rom_data <= table_mem[rom_addr];

    int n_checks = 0;
    int n_fail   = 0;

    int          cyc       = 0;
    int          prot_viol = 0;
    int          n_starts  = 0;
    int          last_rise = -100;
    int          busy_cnt  = 0;
    int          sccb_len  = 20;
    int          hang_idx  = -1;
    logic        prev_start = 1'b0;
    logic        in_txn     = 1'b0;
    logic [23:0] txn_ad     = '0;
    logic [23:0] st_q[$];
    int          st_cyc[$];
    logic [23:0] exp_q[$];
    int          exp_end;
    int          rel_cyc;
    int          term_cyc;
    bit          term_ok;

    // Protocol monitor followed by the SCCB stage model (ready low for sccb_len cycles per start).
    always @(negedge clk_sys) begin
        cyc = cyc + 1;
        if (start_ov5640) begin
            if (ready_ov5640 !== 1'b1) prot_viol++;
            if (prev_start) prot_viol++;
            if (cyc - last_rise < 3) prot_viol++;
            st_q.push_back({address_ov5640, data_ov5640});
            st_cyc.push_back(cyc);
            n_starts++;
            in_txn = 1'b1;
            txn_ad = {address_ov5640, data_ov5640};
        end else if (in_txn && ({address_ov5640, data_ov5640} !== txn_ad)) begin
            prot_viol++;
        end
        if (config_busy === (config_done | config_error)) prot_viol++;
        if (select_initial_cam !== (config_busy ? CAM : 2'b11)) prot_viol++;
        prev_start = start_ov5640;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin
                ready_ov5640 = 1'b1;
                last_rise    = cyc;
                in_txn       = 1'b0;
            end
        end
        if (start_ov5640 && (n_starts - 1) != hang_idx) begin
            ready_ov5640 = 1'b0;
            busy_cnt     = sccb_len;
        end
    end

    task automatic clear_table();
        for (int i = 0; i < DEPTH; i++) table_mem[i] = 24'hFFFF00;
    endtask

    // Reference walk of the table: writes in order, and the index where the walk stops.
    task automatic compute_expect();
        exp_q.delete();
        exp_end = DEPTH - 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (table_mem[i][23:8] == 16'hFFFF) begin
                exp_end = i;
                break;
            end
            if (table_mem[i][23:8] != 16'hFFFE) exp_q.push_back(table_mem[i]);
        end
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        restart      = 1'b0;
        busy_cnt     = 0;
        ready_ov5640 = 1'b1;
        in_txn       = 1'b0;
        prev_start   = 1'b0;
        last_rise    = -100;
        prot_viol    = 0;
        n_starts     = 0;
        st_q.delete();
        st_cyc.delete();
        repeat (3) @(negedge clk_sys);
        #1;
        reset   = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic wait_term(input int budget);
        term_ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_sys);
            #1;
            if (config_done || config_error) begin
                term_ok = 1'b1;
                break;
            end
        end
        term_cyc = cyc;
        n_checks++;
        if (!term_ok) begin
            n_fail++;
            $display("FAIL terminate: no DONE/ERROR within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        logic [35:0] got;
        logic [35:0] want;
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        #1;
        got  = {rom_addr, start_ov5640, address_ov5640, data_ov5640, config_busy,
                select_initial_cam, config_done, config_error, err_index};
        want = {3'd0, 1'b0, 16'h0000, 8'h00, 1'b1, CAM, 1'b0, 1'b0, 3'd0};
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", got, want);
        end
        n_checks++;
        if (config_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 1", config_busy);
        end
        n_checks++;
        if (select_initial_cam !== CAM) begin
            n_fail++;
            $display("FAIL reset_sel: got %b want %b", select_initial_cam, CAM);
        end
    endtask

    task automatic test_basic();
        clear_table();
        table_mem[0] = 24'h300882;
        table_mem[1] = 24'h310303;
        table_mem[2] = 24'hFFFF00;
        sccb_len = 20;
        hang_idx = -1;
        compute_expect();
        apply_reset();
        n_checks++;
        if (select_initial_cam !== CAM) begin
            n_fail++;
            $display("FAIL basic_sel_busy: got %b want %b", select_initial_cam, CAM);
        end
        wait_term(2000);
        n_checks++;
        if (st_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d starts want %0d", st_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (st_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: got %h want %h", k, st_q[k], exp_q[k]);
                end
            end
            n_checks++;
            if (st_cyc[0] - rel_cyc < PW) begin
                n_fail++;
                $display("FAIL basic_power_wait: first start after %0d cycles want >= %0d",
                         st_cyc[0] - rel_cyc, PW);
            end
        end
        n_checks++;
        if ({config_done, config_error, config_busy, select_initial_cam} !== 5'b10011) begin
            n_fail++;
            $display("FAIL basic_done: got done/err/busy/sel %b want 10011",
                     {config_done, config_error, config_busy, select_initial_cam});
        end
        n_checks++;
        if (prot_viol !== 0) begin
            n_fail++;
            $display("FAIL basic_protocol: got %0d violations want 0", prot_viol);
        end
    endtask

    task automatic test_delay();
        int t5;
        int t0;
        clear_table();
        table_mem[0] = 24'hFFFE05;
        table_mem[1] = 24'h300802;
        sccb_len = 4;
        apply_reset();
        wait_term(2000);
        t5 = (st_cyc.size() > 0) ? st_cyc[0] - rel_cyc : -1;
        n_checks++;
        if (st_q.size() != 1 || st_q[0] !== 24'h300802) begin
            n_fail++;
            $display("FAIL delay_write: got %0d starts first %h want 1 start 300802",
                     st_q.size(), (st_q.size() > 0) ? st_q[0] : 24'h0);
        end
        n_checks++;
        if (t5 < PW + 5 * DU) begin
            n_fail++;
            $display("FAIL delay_gap: start after %0d cycles want >= %0d", t5, PW + 5 * DU);
        end
        table_mem[0] = 24'hFFFE00;
        apply_reset();
        wait_term(2000);
        t0 = (st_cyc.size() > 0) ? st_cyc[0] - rel_cyc : -1;
        n_checks++;
        if (t5 - t0 != 5 * DU) begin
            n_fail++;
            $display("FAIL delay_zero: delay5 vs delay0 difference %0d want %0d", t5 - t0, 5 * DU);
        end
        n_checks++;
        if (config_done !== 1'b1 || prot_viol !== 0) begin
            n_fail++;
            $display("FAIL delay_done: got done %b viol %0d want done 1 viol 0", config_done, prot_viol);
        end
    endtask

    task automatic test_timeout();
        clear_table();
        table_mem[0] = 24'h300801;
        table_mem[1] = 24'h300902;
        sccb_len = 5;
        hang_idx = 1;
        apply_reset();
        wait_term(2000);
        n_checks++;
        if ({config_error, config_done, config_busy, select_initial_cam} !== 5'b10011) begin
            n_fail++;
            $display("FAIL timeout_state: got err/done/busy/sel %b want 10011",
                     {config_error, config_done, config_busy, select_initial_cam});
        end
        n_checks++;
        if (err_index !== 3'd1) begin
            n_fail++;
            $display("FAIL timeout_index: got %0d want 1", err_index);
        end
        n_checks++;
        if (st_cyc.size() != 2 || term_cyc - st_cyc[1] != TO) begin
            n_fail++;
            $display("FAIL timeout_latency: starts %0d, error %0d cycles after start, want 2 and %0d",
                     st_cyc.size(), (st_cyc.size() > 1) ? term_cyc - st_cyc[1] : -1, TO);
        end
        repeat (100) @(negedge clk_sys);
        #1;
        n_checks++;
        if (n_starts != 2 || config_error !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_hold: got %0d starts err %b want 2 starts err 1", n_starts, config_error);
        end
        hang_idx = -1;
    endtask

    task automatic test_full_table();
        clear_table();
        for (int i = 0; i < DEPTH; i++)
            table_mem[i] = {16'($urandom_range(65533, 0)), 8'($urandom)};
        sccb_len = int'($urandom_range(6, 2));
        compute_expect();
        apply_reset();
        wait_term(3000);
        repeat (10) @(negedge clk_sys);
        #1;
        n_checks++;
        if (st_q.size() != DEPTH) begin
            n_fail++;
            $display("FAIL full_count: got %0d starts want %0d", st_q.size(), DEPTH);
        end else begin
            foreach (exp_q[k]) begin
                n_checks++;
                if (st_q[k] !== exp_q[k]) begin
                    n_fail++;
                    $display("FAIL full_write%0d: got %h want %h", k, st_q[k], exp_q[k]);
                end
            end
        end
        n_checks++;
        if (config_done !== 1'b1 || rom_addr !== 3'd7) begin
            n_fail++;
            $display("FAIL full_end: got done %b rom_addr %0d want done 1 rom_addr 7", config_done, rom_addr);
        end
    endtask

    task automatic test_random();
        int k;
        for (int it = 0; it < 6; it++) begin
            clear_table();
            for (int i = 0; i < DEPTH; i++) begin
                k = int'($urandom_range(9, 0));
                if (k == 6 || k == 7)
                    table_mem[i] = {16'hFFFE, 8'($urandom_range(3, 0))};
                else if (k == 8)
                    table_mem[i] = 24'hFFFF00;
                else
                    table_mem[i] = {16'($urandom_range(65533, 0)), 8'($urandom)};
            end
            sccb_len = int'($urandom_range(6, 1));
            compute_expect();
            apply_reset();
            wait_term(3000);
            n_checks++;
            if (st_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d starts want %0d", it, st_q.size(), exp_q.size());
            end else begin
                foreach (exp_q[j]) begin
                    n_checks++;
                    if (st_q[j] !== exp_q[j]) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d: got %h want %h", it, j, st_q[j], exp_q[j]);
                    end
                end
            end
            n_checks++;
            if (config_done !== 1'b1 || int'(rom_addr) != exp_end || prot_viol != 0) begin
                n_fail++;
                $display("FAIL rand%0d_end: got done %b rom_addr %0d viol %0d want 1 %0d 0",
                         it, config_done, rom_addr, prot_viol, exp_end);
            end
        end
    endtask

    task automatic test_restart();
        bit found;
        int r;
        clear_table();
        table_mem[0] = 24'h300811;
        table_mem[1] = 24'h300922;
        table_mem[2] = 24'h300A33;
        sccb_len = 6;
        compute_expect();
        apply_reset();
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_sys);
            #1;
            if (!ready_ov5640) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL restart_busy_wait: ready never dropped within 500 cycles");
        end
        @(negedge clk_sys);
        #1;
        restart = 1'b1;
        @(negedge clk_sys);
        #1;
        restart = 1'b0;
        wait_term(2000);
        n_checks++;
        if (st_q.size() != 3 || config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_ignored: got %0d starts done %b want 3 starts done 1", st_q.size(), config_done);
        end

        st_q.delete();
        st_cyc.delete();
        @(negedge clk_sys);
        #1;
        restart = 1'b1;
        r = cyc;
        @(negedge clk_sys);
        #1;
        restart = 1'b0;
        n_checks++;
        if ({config_done, config_error, config_busy, select_initial_cam, rom_addr} !== {3'b001, CAM, 3'd0}) begin
            n_fail++;
            $display("FAIL restart_clear: got done/err/busy/sel/addr %b want %b",
                     {config_done, config_error, config_busy, select_initial_cam, rom_addr},
                     {3'b001, CAM, 3'd0});
        end
        wait_term(2000);
        n_checks++;
        if (st_q.size() != 3 || st_q[0] !== exp_q[0] || st_q[2] !== exp_q[2] || st_cyc[0] - r < PW) begin
            n_fail++;
            $display("FAIL restart_rerun: got %0d starts, first %h after %0d cycles, want 3 starts %h after >= %0d",
                     st_q.size(), (st_q.size() > 0) ? st_q[0] : 24'h0,
                     (st_cyc.size() > 0) ? st_cyc[0] - r : -1, exp_q[0], PW);
        end

        st_q.delete();
        st_cyc.delete();
        @(negedge clk_sys);
        #1;
        restart = 1'b1;
        @(negedge clk_sys);
        #1;
        restart = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk_sys);
            #1;
            if (start_ov5640) begin
                found = 1'b1;
                break;
            end
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (!found || {start_ov5640, config_busy, select_initial_cam, rom_addr, address_ov5640} !== {1'b0, 1'b1, CAM, 3'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_mid_start: found %b start %b busy %b sel %b addr %0d reg %h want start 0 busy 1 sel %b addr 0 reg 0",
                     found, start_ov5640, config_busy, select_initial_cam, rom_addr, address_ov5640, CAM);
        end
        apply_reset();
        wait_term(2000);
        n_checks++;
        if (st_q.size() != 3 || st_q[0] !== exp_q[0] || st_cyc[0] - rel_cyc < PW || config_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_rerun: got %0d starts first %h done %b, want 3 starts first %h done 1",
                     st_q.size(), (st_q.size() > 0) ? st_q[0] : 24'h0, config_done, exp_q[0]);
        end
        n_checks++;
        if (prot_viol != 0) begin
            n_fail++;
            $display("FAIL restart_protocol: got %0d violations want 0", prot_viol);
        end
    endtask

    initial begin
        clear_table();
        test_reset();
        test_basic();
        test_delay();
        test_timeout();
        test_full_table();
        test_random();
        test_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
